jtframe_sdram_rdbank: RTL and testbench

- Single-bank, read-only SDRAM command engine downstream of the ROM slot arbiter.
- Consumes the arbiter's req/addr handshake and drives SDRAM command/address pins: ACTIVE, then READ with auto-precharge.
- Returns each 16-bit word on the shared data_dst/data_rdy/data_read bus.
- Also owns the power-up init sequence and periodic auto-refresh for its chip.

---
 rtl/jtframe_sdram_rdbank_if.sv | 27 ++
 rtl/jtframe_sdram_rdbank.sv | 205 ++++++++++++++++++++
 tb/tb_jtframe_sdram_rdbank.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_sdram_rdbank_if.sv
`default_nettype none
// +--------------------------------------------------------------+
// | jtframe_sdram_rdbank_if                                      |
// | Arbiter-side request/return bus of the SDRAM read engine.    |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
interface jtframe_sdram_rdbank_if #(
  parameter int SDRAMW = 22
);
  logic              req;
  logic [SDRAMW-1:0] addr;
  logic              ack;
  logic              dst;
  logic              rdy;
  logic [15:0]       dout;

  modport master (
    output req, addr,
    input  ack, dst, rdy, dout
  );

  modport slave (
    input  req, addr,
    output ack, dst, rdy, dout
  );
endinterface
`default_nettype wire

// File: rtl/jtframe_sdram_rdbank.sv
`default_nettype none
// +--------------------------------------------------------------+
// | jtframe_sdram_rdbank                                         |
// | Single-bank read-only SDRAM engine with init and refresh.    |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module jtframe_sdram_rdbank #(
  parameter int         SDRAMW     = 22,
  parameter logic [1:0] BANK       = 2'd0,
  parameter int         CL         = 2,
  parameter int         RCD        = 2,
  parameter int         RC         = 7,
  parameter int         RFC        = 7,
  parameter int         INIT_WAIT  = 10000,
  parameter int         REF_PERIOD = 780
) (
  input  logic                  clk,
  input  logic                  rst,
  jtframe_sdram_rdbank_if.slave rd_bus,
  input  logic [15:0]           sdram_dq_i,
  output logic [12:0]           sdram_a_o,
  output logic [1:0]            sdram_ba_o,
  output logic [3:0]            sdram_cmd_o,
  output logic [1:0]            sdram_dqm_o,
  output logic                  sdram_cke_o
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam int MAX1     = (INIT_WAIT > RC)  ? INIT_WAIT : RC;
  localparam int MAX2     = (MAX1 > RFC)      ? MAX1 : RFC;
  localparam int MAX3     = (MAX2 > RCD)      ? MAX2 : RCD;
  localparam int MAX4     = (MAX3 > CL)       ? MAX3 : CL;
  localparam int WAIT_MAX = (MAX4 > 3)        ? MAX4 : 3;
  localparam int CNTW     = $clog2(WAIT_MAX + 1);
  localparam int REFW     = (REF_PERIOD > 1) ? $clog2(REF_PERIOD + 1) : 1;
  localparam int EXTW     = (SDRAMW > 22) ? SDRAMW : 22;

  // Counters hold "cycles left minus one" so the next command lands exactly N cycles later
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'((INIT_WAIT > 0) ? INIT_WAIT - 1 : 0);
  localparam logic [CNTW-1:0] CNT_RC   = CNTW'((RC  > 0) ? RC  - 1 : 0);
  localparam logic [CNTW-1:0] CNT_RFC  = CNTW'((RFC > 0) ? RFC - 1 : 0);
  localparam logic [CNTW-1:0] CNT_RCD  = CNTW'((RCD > 0) ? RCD - 1 : 0);
  localparam logic [CNTW-1:0] CNT_CL   = CNTW'((CL  > 0) ? CL  - 1 : 0);
  localparam logic [CNTW-1:0] CNT_MRS  = CNTW'(2);
  localparam logic [REFW-1:0] REF_LAST = REFW'((REF_PERIOD > 0) ? REF_PERIOD - 1 : 0);

  // Single-location write, CAS latency, sequential, burst length 1
  localparam logic [12:0] MODE_WORD = {3'b000, 1'b1, 2'b00, 3'(CL), 1'b0, 3'b000};

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_PRE  = 3'd1,
    S_REF1 = 3'd2,
    S_REF2 = 3'd3,
    S_IDLE = 3'd4,
    S_ACT  = 3'd5,
    S_RD   = 3'd6
  } state_t;

  state_t          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] trc_q;
  logic [3:0]      cmd_q;
  logic [12:0]     a_q;
  logic [1:0]      dqm_q;
  logic            ack_q;
  logic            dst_q;
  logic            rdy_q;
  logic [15:0]     dout_q;
  logic [8:0]      col_q;
  logic            ref_en_q;
  logic [REFW-1:0] ref_cnt_q;
  logic [REFW-1:0] ref_cnt_d;
  logic            ref_pend_q;
  logic            ref_pend_d;

  logic [EXTW-1:0] w_addr_ext;
  logic [12:0]     w_row;
  logic            w_ref_go;

  assign w_addr_ext = EXTW'(rd_bus.addr);
  assign w_row      = w_addr_ext[21:9];
  assign w_ref_go   = (state_q == S_IDLE) && (trc_q == '0) && ref_pend_q;

  // An expiry landing on the cycle the REFRESH goes out re-arms the pending flag
  always_comb begin
    ref_cnt_d  = ref_cnt_q;
    ref_pend_d = ref_pend_q & ~w_ref_go;
    if (ref_en_q) begin
      if (ref_cnt_q == REF_LAST) begin
        ref_cnt_d  = '0;
        ref_pend_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_INIT;
      cnt_q    <= CNT_INIT;
      trc_q    <= '0;
      cmd_q    <= CMD_NOP;
      a_q      <= '0;
      dqm_q    <= 2'b11;
      ack_q    <= 1'b0;
      dst_q    <= 1'b0;
      rdy_q    <= 1'b0;
      dout_q   <= '0;
      col_q    <= '0;
      ref_en_q <= 1'b0;
    end else begin
      cmd_q <= CMD_NOP;
      ack_q <= 1'b0;
      dst_q <= 1'b0;
      rdy_q <= dst_q;
      if (dst_q) dout_q <= sdram_dq_i;
      if (trc_q != '0) trc_q <= trc_q - 1'b1;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;

      case (state_q)
        S_INIT: if (cnt_q == '0) begin
          cmd_q   <= CMD_PRE;
          a_q     <= 13'h0400;
          cnt_q   <= CNT_RC;
          state_q <= S_PRE;
        end
        S_PRE: if (cnt_q == '0) begin
          cmd_q   <= CMD_REF;
          cnt_q   <= CNT_RFC;
          state_q <= S_REF1;
        end
        S_REF1: if (cnt_q == '0) begin
          cmd_q   <= CMD_REF;
          cnt_q   <= CNT_RFC;
          state_q <= S_REF2;
        end
        S_REF2: if (cnt_q == '0) begin
          cmd_q    <= CMD_MRS;
          a_q      <= MODE_WORD;
          trc_q    <= CNT_MRS;
          dqm_q    <= 2'b00;
          ref_en_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        S_IDLE: begin
          // Refresh wins over a waiting request; both wait for tRC to drain
          if (w_ref_go) begin
            cmd_q <= CMD_REF;
            trc_q <= CNT_RFC;
          end else if ((trc_q == '0) && rd_bus.req) begin
            cmd_q   <= CMD_ACT;
            a_q     <= w_row;
            ack_q   <= 1'b1;
            col_q   <= w_addr_ext[8:0];
            trc_q   <= CNT_RC;
            cnt_q   <= CNT_RCD;
            state_q <= S_ACT;
          end
        end
        S_ACT: if (cnt_q == '0) begin
          cmd_q   <= CMD_RD;
          a_q     <= {2'b00, 1'b1, 1'b0, col_q};
          cnt_q   <= CNT_CL;
          state_q <= S_RD;
        end
        S_RD: if (cnt_q == '0) begin
          dst_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign rd_bus.ack  = ack_q;
  assign rd_bus.dst  = dst_q;
  assign rd_bus.rdy  = rdy_q;
  assign rd_bus.dout = dout_q;

  assign sdram_a_o   = a_q;
  assign sdram_ba_o  = BANK;
  assign sdram_cmd_o = cmd_q;
  assign sdram_dqm_o = dqm_q;
  assign sdram_cke_o = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_sdram_rdbank.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_jtframe_sdram_rdbank                                      |
// | Directed bench: init, reads, refresh collision, reset, CL=3. |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module tb_jtframe_sdram_rdbank;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  logic        clk;
  logic        rst_v  [3];
  logic        req_v  [3];
  logic [21:0] addr_v [3];
  logic [15:0] dq_v   [3];
  logic [12:0] a_w    [3];
  logic [1:0]  ba_w   [3];
  logic [3:0]  cmd_w  [3];
  logic [1:0]  dqm_w  [3];
  logic        cke_w  [3];
  logic        ack_w  [3];
  logic        dst_w  [3];
  logic        rdy_w  [3];
  logic [15:0] dout_w [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: CL=2, BANK=1; 1: CL=3; 2: REF_PERIOD=20
  for (genvar g = 0; g < 3; g++) begin : g_dut
    jtframe_sdram_rdbank_if #(.SDRAMW(22)) u_bus ();
    jtframe_sdram_rdbank #(
      .SDRAMW     (22),
      .BANK       ((g == 0) ? 2'd1 : 2'd0),
      .CL         ((g == 1) ? 3 : 2),
      .RCD        (2),
      .RC         (7),
      .RFC        (7),
      .INIT_WAIT  (20),
      .REF_PERIOD ((g == 2) ? 20 : 780)
    ) u_dut (
      .clk         (clk),
      .rst         (rst_v[g]),
      .rd_bus      (u_bus),
      .sdram_dq_i  (dq_v[g]),
      .sdram_a_o   (a_w[g]),
      .sdram_ba_o  (ba_w[g]),
      .sdram_cmd_o (cmd_w[g]),
      .sdram_dqm_o (dqm_w[g]),
      .sdram_cke_o (cke_w[g])
    );
    assign u_bus.req  = req_v[g];
    assign u_bus.addr = addr_v[g];
    assign ack_w[g]   = u_bus.ack;
    assign dst_w[g]   = u_bus.dst;
    assign rdy_w[g]   = u_bus.rdy;
    assign dout_w[g]  = u_bus.dout;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic [21:0] addr;
    logic [15:0] dq;
    logic [3:0]  cmd;
    logic        chk_a;
    logic [12:0] a;
    logic        ack;
    logic        dst;
    logic        rdy;
    logic        chk_dout;
    logic [15:0] dout;
  } vec_t;

  vec_t tv [15];

  int pre_n, pre_at, ref_n, ref1_at, ref2_at, mrs_n, mrs_at, other_n, early_ack, pulses;
  int act_at, rd_at, dst_at, rdy_at, ack_n, post_ref_at, post_ref_n, first_at;
  logic        pre_a10;
  logic [12:0] mrs_a;
  logic [3:0]  first_cmd;
  logic [15:0] dout_at_rdy;
  logic        found;

  initial begin
    // Timeline of two reads starting at the first ACTIVE (T0); second request held from T0+1
    tv[0]  = '{1'b1, 22'h12345,  16'hDEAD, CMD_ACT, 1'b1, 13'h0091, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tv[1]  = '{1'b1, 22'h3FFFFF, 16'hDEAD, CMD_NOP, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tv[2]  = '{1'b1, 22'h3FFFFF, 16'hDEAD, CMD_RD,  1'b1, 13'h0545, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tv[3]  = '{1'b1, 22'h3FFFFF, 16'hDEAD, CMD_NOP, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tv[4]  = '{1'b1, 22'h3FFFFF, 16'hBEEF, CMD_NOP, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tv[5]  = '{1'b1, 22'h3FFFFF, 16'hDEAD, CMD_NOP, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hBEEF};
    tv[6]  = '{1'b1, 22'h3FFFFF, 16'hDEAD, CMD_NOP, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    tv[7]  = '{1'b1, 22'h3FFFFF, 16'hDEAD, CMD_ACT, 1'b1, 13'h1FFF, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    tv[8]  = '{1'b0, 22'h000000, 16'hDEAD, CMD_NOP, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    tv[9]  = '{1'b0, 22'h000000, 16'hDEAD, CMD_RD,  1'b1, 13'h05FF, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    tv[10] = '{1'b0, 22'h000000, 16'hDEAD, CMD_NOP, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    tv[11] = '{1'b0, 22'h000000, 16'h1234, CMD_NOP, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF};
    tv[12] = '{1'b0, 22'h000000, 16'hDEAD, CMD_NOP, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234};
    tv[13] = '{1'b0, 22'h000000, 16'hDEAD, CMD_NOP, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
    tv[14] = '{1'b0, 22'h000000, 16'hDEAD, CMD_NOP, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};

    for (int i = 0; i < 3; i++) begin
      rst_v[i]  = 1'b1;
      req_v[i]  = 1'b0;
      addr_v[i] = '0;
      dq_v[i]   = 16'hDEAD;
    end

    // ---------------- instance 0: reset values ----------------
    req_v[0]  = 1'b1;
    addr_v[0] = 22'h12345;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd",  cmd_w[0],  CMD_NOP);
    check("rst_a",    a_w[0],    13'h0000);
    check("rst_ba",   ba_w[0],   2'd1);
    check("rst_ack",  ack_w[0],  1'b0);
    check("rst_dst",  dst_w[0],  1'b0);
    check("rst_rdy",  rdy_w[0],  1'b0);
    check("rst_dout", dout_w[0], 16'h0000);
    check("rst_dqm",  dqm_w[0],  2'b11);
    check("rst_cke",  cke_w[0],  1'b1);
    @(posedge clk); #1;
    rst_v[0] = 1'b0;

    // ---------------- instance 0: init with req held ----------------
    pre_n = 0; ref_n = 0; mrs_n = 0; other_n = 0; early_ack = 0;
    pre_at = -1; ref1_at = -1; ref2_at = -1; mrs_at = -1; pre_a10 = 1'b0; mrs_a = '0;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      case (cmd_w[0])
        CMD_PRE: begin pre_n++; pre_at = k; pre_a10 = a_w[0][10]; end
        CMD_REF: begin ref_n++; if (ref_n == 1) ref1_at = k; else ref2_at = k; end
        CMD_MRS: begin mrs_n++; mrs_at = k; mrs_a = a_w[0]; end
        CMD_NOP: ;
        default: other_n++;
      endcase
      if (ack_w[0]) early_ack++;
      @(posedge clk); #1;
    end
    check("init_pre_count", pre_n,   1);
    check("init_pre_cycle", pre_at,  20);
    check("init_pre_a10",   pre_a10, 1'b1);
    check("init_ref_count", ref_n,   2);
    check("init_ref1_cyc",  ref1_at, 27);
    check("init_ref2_cyc",  ref2_at, 34);
    check("init_mrs_count", mrs_n,   1);
    check("init_mrs_cycle", mrs_at,  41);
    check("init_mrs_a",     mrs_a,   13'h0220);
    check("init_other_cmd", other_n, 0);
    check("init_early_ack", early_ack, 0);

    // ---------------- instance 0: single and back-to-back reads ----------------
    for (int i = 0; i < 15; i++) begin
      req_v[0]  = tv[i].req;
      addr_v[0] = tv[i].addr;
      dq_v[0]   = tv[i].dq;
      @(negedge clk);
      check($sformatf("v%0d_cmd", i), cmd_w[0], tv[i].cmd);
      if (tv[i].chk_a) check($sformatf("v%0d_a", i), a_w[0], tv[i].a);
      check($sformatf("v%0d_ack", i), ack_w[0], tv[i].ack);
      check($sformatf("v%0d_dst", i), dst_w[0], tv[i].dst);
      check($sformatf("v%0d_rdy", i), rdy_w[0], tv[i].rdy);
      if (tv[i].chk_dout) check($sformatf("v%0d_dout", i), dout_w[0], tv[i].dout);
      if (i == 0) check("idle_dqm", dqm_w[0], 2'b00);
      @(posedge clk); #1;
    end

    // ---------------- instance 0: reset in the middle of a read ----------------
    req_v[0]  = 1'b1;
    addr_v[0] = 22'h00200;
    dq_v[0]   = 16'hBEEF;
    found     = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (ack_w[0]) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("mid_ack_seen", found, 1'b1);
    check("mid_act_row", a_w[0], 13'h0001);
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_read_cmd", cmd_w[0], CMD_RD);
    check("mid_read_a",   a_w[0],   13'h0400);
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    pulses = 0; first_at = -1; first_cmd = CMD_NOP;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("mid_nop_cmd", cmd_w[0], CMD_NOP);
        check("mid_dqm",     dqm_w[0], 2'b11);
      end
      if (dst_w[0] || rdy_w[0]) pulses++;
      if (cmd_w[0] != CMD_NOP && first_at < 0) begin first_at = k; first_cmd = cmd_w[0]; end
      @(posedge clk); #1;
    end
    check("mid_no_pulses",  pulses,    0);
    check("mid_restart_at", first_at,  20);
    check("mid_restart_pre", first_cmd, CMD_PRE);
    check("mid_dout_clear", dout_w[0], 16'h0000);
    rst_v[0] = 1'b1;

    // ---------------- instance 1: CL=3 single read ----------------
    req_v[1]  = 1'b1;
    addr_v[1] = 22'h12345;
    @(posedge clk); #1;
    rst_v[1] = 1'b0;
    mrs_at = -1; mrs_a = '0; act_at = -1; rd_at = -1; dst_at = -1; rdy_at = -1; ack_n = 0;
    dout_at_rdy = '0;
    for (int k = 0; k < 56; k++) begin
      dq_v[1] = (k == 49) ? 16'hBEEF : 16'hDEAD;
      @(negedge clk);
      if (cmd_w[1] == CMD_MRS) begin mrs_at = k; mrs_a = a_w[1]; end
      if (cmd_w[1] == CMD_ACT && act_at < 0) act_at = k;
      if (cmd_w[1] == CMD_RD && rd_at < 0) rd_at = k;
      if (dst_w[1] && dst_at < 0) dst_at = k;
      if (rdy_w[1] && rdy_at < 0) begin rdy_at = k; dout_at_rdy = dout_w[1]; end
      if (ack_w[1]) begin ack_n++; req_v[1] = 1'b0; end
      @(posedge clk); #1;
    end
    check("cl3_mrs_cycle", mrs_at, 41);
    check("cl3_mrs_a",     mrs_a,  13'h0230);
    check("cl3_act_cycle", act_at, 44);
    check("cl3_rd_cycle",  rd_at,  46);
    check("cl3_dst_cycle", dst_at, 49);
    check("cl3_rdy_cycle", rdy_at, 50);
    check("cl3_dout",      dout_at_rdy, 16'hBEEF);
    check("cl3_ack_count", ack_n,  1);
    rst_v[1] = 1'b1;

    // ---------------- instance 2: refresh collides with request ----------------
    addr_v[2] = 22'h12345;
    @(posedge clk); #1;
    rst_v[2] = 1'b0;
    mrs_at = -1; act_at = -1; rdy_at = -1; ack_n = 0; post_ref_at = -1; post_ref_n = 0;
    for (int k = 0; k < 76; k++) begin
      if (k == 61) req_v[2] = 1'b1;
      @(negedge clk);
      if (cmd_w[2] == CMD_MRS) mrs_at = k;
      if (cmd_w[2] == CMD_REF && k > 41 && k < 69) begin
        post_ref_n++;
        if (post_ref_at < 0) post_ref_at = k;
      end
      if (cmd_w[2] == CMD_ACT && act_at < 0) act_at = k;
      if (rdy_w[2] && rdy_at < 0) rdy_at = k;
      if (ack_w[2]) begin ack_n++; req_v[2] = 1'b0; if (k != 69) early_ack++; end
      @(posedge clk); #1;
    end
    check("ref_mrs_cycle", mrs_at,      41);
    check("ref_first_at",  post_ref_at, 62);
    check("ref_count",     post_ref_n,  1);
    check("ref_act_cycle", act_at,      69);
    check("ref_ack_count", ack_n,       1);
    check("ref_ack_early", early_ack,   0);
    check("ref_rdy_cycle", rdy_at,      74);
    rst_v[2] = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
